// File: rtl/fetch_pc_unit_pkg.sv
// Shared constants for the IF-stage PC unit: opcodes, default reset PC and
// instruction length.
package fetch_pc_unit_pkg;

   localparam logic [6:0]  OPC_BRANCH       = 7'b1100011;
   localparam logic [6:0]  OPC_JAL          = 7'b1101111;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
   localparam int unsigned INSTR_BYTES      = 4;

   // True when the instruction's major opcode equals opc.
   function automatic logic has_opcode(input logic [31:0] instr, input logic [6:0] opc);
      return (instr[6:0] == opc);
   endfunction

endpackage

// File: rtl/fetch_pc_unit_branch_target_gen.sv
// Combinational target generator: sign-extends the B-immediate (and, when
// FETCH_PC_JAL_EN is defined, the J-immediate) of the fetched instruction and
// adds it to the fetch PC. Arithmetic wraps modulo 2^ADDR_W. ADDR_W >= 21.
module branch_target_gen #(
   parameter int ADDR_W = 32
) (
   input  logic [31:0]       instr,
   input  logic [ADDR_W-1:0] pc,
`ifdef FETCH_PC_JAL_EN
   output logic [ADDR_W-1:0] jal_target,
`endif
   output logic [ADDR_W-1:0] target
);

   logic [12:0]       b_imm;
   logic [ADDR_W-1:0] b_imm_ext;

   // Conditional-branch target from the scattered B-immediate fields.
   always_comb begin
      b_imm     = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      b_imm_ext = {{(ADDR_W-13){b_imm[12]}}, b_imm};
      target    = pc + b_imm_ext;
   end

`ifdef FETCH_PC_JAL_EN
   logic [20:0]       j_imm;
   logic [ADDR_W-1:0] j_imm_ext;
   logic              unused_opcode;

   // JAL target from the J-immediate fields.
   always_comb begin
      j_imm      = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      j_imm_ext  = {{(ADDR_W-21){j_imm[20]}}, j_imm};
      jal_target = pc + j_imm_ext;
   end

   assign unused_opcode = ^instr[6:0];
`else
   logic unused_fields;
   assign unused_fields = ^{instr[24:12], instr[6:0]};
`endif

endmodule

// File: rtl/fetch_pc_unit.sv
// IF-stage PC generator with IF/ID branch tracking. Flags conditional branches
// for the predictor, follows predicted-taken branches with no bubble, carries
// the prediction and the not-chosen path into ID, and redirects/flushes on a
// mispredict. Optional JAL redirect in IF: define FETCH_PC_JAL_EN.
module fetch_pc_unit
   import fetch_pc_unit_pkg::*;
#(
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall_i,
   input  logic [31:0]       IF_instr_i,
   input  logic              taken_i,
   input  logic              ID_taken_actual_i,
   output logic [ADDR_W-1:0] pc_o,
   output logic              IF_branch_o,
   output logic              ID_branch_o,
   output logic              wrong_o,
   output logic              flush_o
);

   logic [ADDR_W-1:0] pc;
   logic              id_branch;
   logic              id_pred;
   logic [ADDR_W-1:0] id_recover;

   logic [ADDR_W-1:0] seq_pc;
   logic [ADDR_W-1:0] target_pc;
   logic [ADDR_W-1:0] next_pc;
   logic              is_branch;
   logic              wrong;
   logic              flush;

`ifdef FETCH_PC_JAL_EN
   logic [ADDR_W-1:0] jal_pc;
   logic              is_jal;
   assign is_jal = has_opcode(IF_instr_i, OPC_JAL);
`endif

   branch_target_gen #(
      .ADDR_W (ADDR_W)
   ) u_target (
      .instr      (IF_instr_i),
      .pc         (pc),
`ifdef FETCH_PC_JAL_EN
      .jal_target (jal_pc),
`endif
      .target     (target_pc)
   );

   // Decode, mispredict detection and next-PC selection (flush beats any
   // IF-stage redirect, so a branch behind a mispredict is discarded).
   always_comb begin
      is_branch = has_opcode(IF_instr_i, OPC_BRANCH);
      seq_pc    = pc + ADDR_W'(INSTR_BYTES);
      wrong     = id_branch && (id_pred != ID_taken_actual_i);
      flush     = wrong && !stall_i;
      next_pc   = seq_pc;
      if (flush) begin
         next_pc = id_recover;
      end else if (is_branch && taken_i) begin
         next_pc = target_pc;
`ifdef FETCH_PC_JAL_EN
      end else if (is_jal) begin
         next_pc = jal_pc;
`endif
      end
   end

   // PC and IF/ID registers; a stall freezes everything, a flushed slot
   // enters ID as a bubble.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc         <= RESET_PC;
         id_branch  <= 1'b0;
         id_pred    <= 1'b0;
         id_recover <= '0;
      end else if (!stall_i) begin
         pc         <= next_pc;
         id_branch  <= is_branch && !flush;
         id_pred    <= taken_i;
         id_recover <= taken_i ? seq_pc : target_pc;
      end
   end

   assign pc_o        = pc;
   assign IF_branch_o = is_branch;
   assign ID_branch_o = id_branch;
   assign wrong_o     = wrong;
   assign flush_o     = flush;

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- IF-stage PC generator and IF/ID branch-tracking pipe; sits directly upstream of the 2-bit saturating predictor.
- Decodes the fetched instruction to flag conditional branches (drives predictor IF_branch_i).
- Consumes the predictor's taken decision and redirects fetch to the branch target.
- Carries prediction metadata into ID and produces the misprediction indication (drives predictor ID_branch_i / wrong_i), plus the recovery redirect and flush.

Parameters:
- ADDR_W, 32, PC width in bits.
- RESET_PC, 32'h0000_0000, fetch address after reset.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- stall_i  in  1  pipeline stall; freezes PC and IF/ID registers.
- IF_instr_i  in  32  instruction word fetched at pc_o this cycle.
- taken_i  in  1  predictor decision for the IF instruction (already gated by IF_branch_o).
- ID_taken_actual_i  in  1  branch outcome resolved in ID; meaningful only when ID_branch_o=1.
- pc_o  out  ADDR_W  current fetch PC.
- IF_branch_o  out  1  IF_instr_i[6:0]==7'b1100011.
- ID_branch_o  out  1  registered branch flag of the instruction now in ID.
- wrong_o  out  1  ID_branch_o && (ID_pred != ID_taken_actual_i).
- flush_o  out  1  wrong_o && !stall_i; kills the IF instruction.

Behaviour:
- Registers: pc, ID_branch, ID_pred, ID_recover (ADDR_W).
- Reset (rst=1 at edge, including mid-operation): pc=RESET_PC, ID_branch=0, ID_pred=0, ID_recover=0. Consequently ID_branch_o=0, wrong_o=0, flush_o=0 and pc_o=RESET_PC in the first cycle after reset.
- B-immediate: {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0}, sign-extended to ADDR_W.
- Branch target: target = pc + imm. seq = pc + 4. All PC arithmetic is modulo 2^ADDR_W (wraps silently).
- Next-PC priority, highest first:
  1. rst
  2. stall_i: hold pc and all IF/ID registers.
  3. flush_o: pc <= ID_recover.
  4. IF_branch_o && taken_i: pc <= target.
  5. else: pc <= seq.
- IF/ID update when !stall_i:
  - ID_branch <= IF_branch_o && !flush_o (a flushed slot enters ID as a bubble).
  - ID_pred <= taken_i.
  - ID_recover <= taken_i ? seq : target (the path not chosen).
- wrong_o is combinational from the held ID registers:
  - It stays asserted for the whole stall if a mispredict coincides with stall_i.
  - The redirect happens on the first unstalled edge.
- The predictor advances only when ID_branch_o && !stall_i. Every resolved branch is therefore seen exactly once.
- Latency:
  - Predicted-taken redirect: 1 cycle (no bubble).
  - Mispredict penalty: 1 bubble (the IF instruction is flushed).
- Back-to-back branches:
  - A mispredict in ID overrides any taken prediction in IF in the same cycle.
  - The IF branch is discarded and does not reach ID.
- taken_i with IF_branch_o=0 is ignored.

Optional Feature:
- Macro FETCH_PC_JAL_EN.
- Defined:
  - IF_instr_i[6:0]==7'b1101111 (JAL) redirects pc <= pc + J-immediate at priority level 4, without prediction.
  - JAL is not flagged as a branch: IF_branch_o=0 and ID_branch=0, so it can never cause wrong_o.
- Undefined: JAL is treated as a sequential instruction; a downstream stage resolves it.

Decomposition:
- Shared package holds:
  - OPC_BRANCH=7'b1100011 and OPC_JAL=7'b1101111.
  - Default RESET_PC.
  - Instruction-length constant 4.
- One combinational sub-module, branch_target_gen: IF_instr_i plus pc in, target out (and J-target when FETCH_PC_JAL_EN).

Test Plan:
- Reset: hold rst 2 cycles with a branch in ID and a mispredict pending -> pc_o=0, ID_branch_o=0, wrong_o=0; next cycle pc_o=4.
- Predicted-taken branch: pc=0x100, IF_instr=BEQ imm=+0x20, taken_i=1 -> next pc_o=0x120; ID_branch_o=1, ID_recover=0x104.
- Mispredict not-taken: BEQ at 0x100, imm=-8, taken_i=0, then ID_taken_actual_i=1 -> wrong_o=1, flush_o=1, next pc_o=0x0F8, following ID_branch_o=0.
- Mispredict under stall: same as the previous case with stall_i=1 for 3 cycles -> wrong_o=1 and flush_o=0 throughout, pc frozen; first unstalled edge pc_o=0x0F8.
- Wrap-around: pc=0xFFFF_FFFC, non-branch -> next pc_o=0x0000_0000. Branch imm=+8 taken -> 0x0000_0004.
- FETCH_PC_JAL_EN: JAL imm=+0x40 at 0x200 -> next pc_o=0x240, IF_branch_o=0. With the macro undefined -> next pc_o=0x204.
